// File: rtl/tern_seq_adder.sv
// tern_seq_adder: sequential unbalanced-ternary adder/subtractor, TPC trits per cycle
module tern_seq_adder #(
  parameter int NTRITS = 8,
  parameter int TPC    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*NTRITS-1:0] a,
  input  logic [2*NTRITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*NTRITS-1:0] sum,
  output logic                cout,
  output logic                enc_err
);
  localparam int W  = 2 * NTRITS;
  localparam int G  = NTRITS / TPC;
  localparam int CW = $clog2(G + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d, a_s, b_s;
  logic           c_q, c_d, err_q, err_d, bad, c_g;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     ta, tb;
  logic [2:0]     t;
  logic [2*TPC-1:0] grp;
  // Sanitise operands at accept: illegal code reads as 0, B is pre-complemented in sub mode
  always_comb begin
    a_s = '0;
    b_s = '0;
    bad = 1'b0;
    ta  = '0;
    tb  = '0;
    for (int i = 0; i < NTRITS; i++) begin
      ta = a[2*i+:2];
      tb = b[2*i+:2];
      bad = bad | (ta == 2'b11) | (tb == 2'b11);
      ta = (ta == 2'b11) ? 2'b00 : ta;
      tb = (tb == 2'b11) ? 2'b00 : tb;
      a_s[2*i+:2] = ta;
      b_s[2*i+:2] = sub ? 2'd2 - tb : tb;
    end
  end
  // Ripple the carry through the current low group of TPC trits
  always_comb begin
    c_g = c_q;
    grp = '0;
    t   = '0;
    for (int i = 0; i < TPC; i++) begin
      t = 3'(a_q[2*i+:2]) + 3'(b_q[2*i+:2]) + 3'(c_g);
      c_g = t >= 3'd3;
      grp[2*i+:2] = c_g ? 2'(t - 3'd3) : t[1:0];
    end
  end
  // Next-state: accept in IDLE, shift one group per RUN cycle, hold in DONE until taken
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d     = a_s;
      b_d     = b_s;
      c_d     = sub | cin;
      err_d   = bad;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> (2 * TPC);
      b_d     = b_q >> (2 * TPC);
      sum_d   = (sum_q >> (2 * TPC)) | (W'(grp) << (W - 2 * TPC));
      c_d     = c_g;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(G - 1)) ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum       = sum_q;
  assign cout      = c_q;
  assign enc_err   = err_q;
endmodule
